// File: rtl/crc16_frame_sched.sv
`default_nettype none
// ============================================================================
// crc16_frame_sched : round-robin frame scheduler feeding one shared CRC-16
// engine. Optional FEED idle timeout enabled by CRC16_SCHED_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module crc16_frame_sched #(
   parameter int ENG_LAT = 2,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [7:0]  req0_data,
   input  logic        req0_last,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_data,
   input  logic        req1_last,
   output logic        req1_ready,
   output logic        eng_init,
   output logic        eng_valid,
   output logic [7:0]  eng_data,
   input  logic [15:0] eng_crc,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_crc,
   output logic        res_src,
   output logic [15:0] res_len,
   output logic        res_err,
   output logic        busy
);

   if (ENG_LAT < 1 || ENG_LAT > 15 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_chk
      $error("crc16_frame_sched: parameter out of range");
   end

   localparam logic [3:0] LAT_INIT = 4'(ENG_LAT);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_INIT = 3'd1,
      S_FEED = 3'd2,
      S_WAIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state_q;
   logic        grant_q;
   logic        prio_q;
   logic [3:0]  lat_q;
   logic [15:0] len_q;
   logic        eng_init_q;
   logic        eng_valid_q;
   logic [7:0]  eng_data_q;
   logic        res_valid_q;
   logic        res_src_q;
   logic        res_err_q;
   logic [15:0] res_crc_q;
   logic [15:0] res_len_q;

   logic        w_g_valid;
   logic        w_g_last;
   logic [7:0]  w_g_data;
   logic        w_feed;
   logic        w_acc;
   logic        w_tmo;
   logic [15:0] len_d;

   assign w_g_valid = grant_q ? req1_valid : req0_valid;
   assign w_g_last  = grant_q ? req1_last  : req0_last;
   assign w_g_data  = grant_q ? req1_data  : req0_data;
   assign w_feed    = (state_q == S_FEED);
   assign w_acc     = w_feed & w_g_valid;
   assign len_d     = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;

`ifdef CRC16_SCHED_TIMEOUT_EN
   logic [15:0] idle_q;
   logic [15:0] w_idle_inc;

   assign w_idle_inc = idle_q + 16'd1;
   assign w_tmo      = w_feed & ~w_g_valid & (w_idle_inc == 16'(TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_q <= 16'd0;
      end else if (!w_feed || w_acc) begin
         idle_q <= 16'd0;
      end else begin
         idle_q <= w_idle_inc;
      end
   end
`else
   assign w_tmo = 1'b0;
`endif

   // Ready is a pure decode of state/grant, so it drops the same edge FEED is left.
   assign req0_ready = w_feed & ~grant_q;
   assign req1_ready = w_feed &  grant_q;
   assign eng_init   = eng_init_q;
   assign eng_valid  = eng_valid_q;
   assign eng_data   = eng_data_q;
   assign res_valid  = res_valid_q;
   assign res_crc    = res_crc_q;
   assign res_src    = res_src_q;
   assign res_len    = res_len_q;
   assign res_err    = res_err_q;
   assign busy       = (state_q != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         grant_q     <= 1'b0;
         prio_q      <= 1'b0;
         lat_q       <= 4'd0;
         len_q       <= 16'd0;
         eng_init_q  <= 1'b0;
         eng_valid_q <= 1'b0;
         eng_data_q  <= 8'd0;
         res_valid_q <= 1'b0;
         res_src_q   <= 1'b0;
         res_err_q   <= 1'b0;
         res_crc_q   <= 16'd0;
         res_len_q   <= 16'd0;
      end else begin
         eng_init_q  <= 1'b0;
         eng_valid_q <= w_acc;
         if (w_acc) begin
            eng_data_q <= w_g_data;
         end
         case (state_q)
            S_IDLE: begin
               if (req0_valid | req1_valid) begin
                  grant_q    <= (req0_valid & req1_valid) ? prio_q : req1_valid;
                  eng_init_q <= 1'b1;
                  state_q    <= S_INIT;
               end
            end
            S_INIT: begin
               len_q   <= 16'd0;
               state_q <= S_FEED;
            end
            S_FEED: begin
               if (w_acc) begin
                  len_q <= len_d;
                  if (w_g_last) begin
                     lat_q   <= LAT_INIT;
                     state_q <= S_WAIT;
                  end
               end else if (w_tmo) begin
                  res_valid_q <= 1'b1;
                  res_err_q   <= 1'b1;
                  res_crc_q   <= 16'd0;
                  res_len_q   <= len_q;
                  res_src_q   <= grant_q;
                  state_q     <= S_DONE;
               end
            end
            S_WAIT: begin
               // Counter hits zero ENG_LAT edges after the engine took the last byte.
               if (lat_q == 4'd0) begin
                  res_valid_q <= 1'b1;
                  res_err_q   <= 1'b0;
                  res_crc_q   <= eng_crc;
                  res_len_q   <= len_q;
                  res_src_q   <= grant_q;
                  state_q     <= S_DONE;
               end else begin
                  lat_q <= lat_q - 4'd1;
               end
            end
            S_DONE: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  res_err_q   <= 1'b0;
                  prio_q      <= ~grant_q;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_crc16_frame_sched.sv
`default_nettype none
// Bench for crc16_frame_sched: frame table plus hand sequences for DONE hold,
// mid-frame reset, length saturation and (when compiled in) the idle timeout.
module tb_crc16_frame_sched;
   localparam int ENG_LAT = 2;
   localparam int TMO     = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [7:0]  req0_data = 8'd0, req1_data = 8'd0;
   logic        req0_last = 1'b0, req1_last = 1'b0;
   logic        req0_ready, req1_ready;
   logic        eng_init, eng_valid;
   logic [7:0]  eng_data;
   logic [15:0] eng_crc;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_crc, res_len;
   logic        res_src, res_err, busy;

   crc16_frame_sched #(.ENG_LAT(ENG_LAT), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .eng_init(eng_init), .eng_valid(eng_valid), .eng_data(eng_data), .eng_crc(eng_crc),
      .res_valid(res_valid), .res_ready(res_ready), .res_crc(res_crc), .res_src(res_src),
      .res_len(res_len), .res_err(res_err), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int b = 0; b < 8; b++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
      return r;
   endfunction

   function automatic logic [15:0] crc_of(input logic [7:0] base, input int n);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int k = 0; k < n; k++) c = crc_byte(c, base + 8'(k));
      return c;
   endfunction

   // CRC-16/CCITT-FALSE engine: one update stage plus one output pipeline stage.
   logic [15:0] eng_r = 16'd0, eng_d1 = 16'd0;
   always @(posedge clk) begin
      if (eng_init)       eng_r <= 16'hFFFF;
      else if (eng_valid) eng_r <= crc_byte(eng_r, eng_data);
      eng_d1 <= eng_r;
   end
   assign eng_crc = eng_d1;

   int cyc_cnt = 0;
   int init_cnt = 0;
   int ovl_cnt = 0;
   int last_acc_cyc = 0;
   int n_chk = 0;
   int n_err = 0;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
   always @(negedge clk) if (eng_init) init_cnt <= init_cnt + 1;

   logic [47:0] outs;
   assign outs = {req0_ready, req1_ready, eng_init, eng_valid, eng_data, res_valid,
                  res_crc, res_src, res_len, res_err, busy};

   logic [7:0] str_b [0:8];

   typedef struct {
      int          src;
      int          n;
      logic [7:0]  base;
      bit          hold;
      logic        exp_src;
      logic [15:0] exp_len;
      logic [15:0] exp_crc;
   } vec_t;
   vec_t tbl [0:5];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input int src, input logic v, input logic [7:0] d, input logic l);
      if (src == 0) begin req0_valid = v; req0_data = d; req0_last = l; end
      else          begin req1_valid = v; req1_data = d; req1_last = l; end
   endtask

   task automatic send(input int src, input int n, input int tot, input logic [7:0] base,
                       input bit use_str, input bit hold_other);
      int i;
      int cyc;
      logic acc;
      logic [7:0] d;
      i = 0;
      cyc = 0;
      drive(1 - src, hold_other, 8'hC3, 1'b0);
      while (i < n && cyc < n + 64) begin
         if (use_str) d = str_b[i];
         else         d = base + 8'(i);
         drive(src, 1'b1, d, (i == tot - 1));
         @(negedge clk);
         acc = (src == 0) ? (req0_valid & req0_ready) : (req1_valid & req1_ready);
         if ((src == 0) ? req1_ready : req0_ready) ovl_cnt++;
         @(posedge clk); #1;
         if (acc) begin
            i++;
            last_acc_cyc = cyc_cnt;
         end
         cyc++;
      end
      drive(src, 1'b0, 8'h00, 1'b0);
      chk("send_progress", i, n);
   endtask

   task automatic get_result(input string nm, input logic exp_src, input logic [15:0] exp_len,
                             input logic [15:0] exp_crc, input logic exp_err, input int hold,
                             input int exp_lat);
      int w;
      logic [34:0] snap;
      bit stable;
      w = 0;
      stable = 1'b1;
      while (!res_valid && w < 100) begin
         @(posedge clk); #1;
         w++;
      end
      chk({nm, " res_valid"}, res_valid, 1);
      if (exp_lat > 0) chk({nm, " latency"}, cyc_cnt - last_acc_cyc, exp_lat);
      chk({nm, " crc"}, res_crc, exp_crc);
      chk({nm, " len"}, res_len, exp_len);
      chk({nm, " src"}, res_src, exp_src);
      chk({nm, " err"}, res_err, exp_err);
      snap = {res_valid, res_crc, res_src, res_len, res_err};
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         if ({res_valid, res_crc, res_src, res_len, res_err} !== snap ||
             req0_ready || req1_ready || eng_init || !busy) stable = 1'b0;
      end
      if (hold > 0) chk({nm, " done_hold"}, stable, 1);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk({nm, " handshake"}, {res_valid, busy}, 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int i0;
      for (int k = 0; k < 9; k++) str_b[k] = 8'h31 + 8'(k);
      tbl[0] = '{0, 1,  8'h00, 1'b0, 1'b0, 16'd1,  16'h0};
      tbl[1] = '{1, 16, 8'h40, 1'b0, 1'b1, 16'd16, 16'h0};
      tbl[2] = '{0, 3,  8'h10, 1'b1, 1'b0, 16'd3,  16'h0};
      tbl[3] = '{1, 3,  8'h20, 1'b1, 1'b1, 16'd3,  16'h0};
      tbl[4] = '{0, 3,  8'h11, 1'b1, 1'b0, 16'd3,  16'h0};
      tbl[5] = '{1, 3,  8'h21, 1'b1, 1'b1, 16'd3,  16'h0};
      for (int k = 0; k < 6; k++) tbl[k].exp_crc = crc_of(tbl[k].base, tbl[k].n);

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", outs, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_reset", outs, 0);

      i0 = init_cnt;
      send(0, 9, 9, 8'h00, 1'b1, 1'b0);
      get_result("str9", 1'b0, 16'd9, 16'h29B1, 1'b0, 0, ENG_LAT + 1);
      chk("str9 init_pulses", init_cnt - i0, 1);

      for (int k = 0; k < 6; k++) begin
         i0 = init_cnt;
         send(tbl[k].src, tbl[k].n, tbl[k].n, tbl[k].base, 1'b0, tbl[k].hold);
         get_result($sformatf("vec%0d", k), tbl[k].exp_src, tbl[k].exp_len, tbl[k].exp_crc,
                    1'b0, 0, ENG_LAT + 1);
         chk($sformatf("vec%0d init_pulses", k), init_cnt - i0, 1);
      end
      drive(0, 1'b0, 8'h00, 1'b0);
      drive(1, 1'b0, 8'h00, 1'b0);
      chk("no_cross_ready", ovl_cnt, 0);

      // DONE held 5 cycles with a pending requester that must not be served.
      send(1, 2, 2, 8'h70, 1'b0, 1'b0);
      drive(0, 1'b1, 8'h55, 1'b1);
      get_result("hold", 1'b1, 16'd2, crc_of(8'h70, 2), 1'b0, 5, ENG_LAT + 1);
      send(0, 1, 1, 8'h55, 1'b0, 1'b0);
      get_result("after_hold", 1'b0, 16'd1, crc_of(8'h55, 1), 1'b0, 0, ENG_LAT + 1);

      // Reset after 4 of 9 bytes, then a clean frame.
      send(0, 4, 9, 8'h00, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midreset_outs", outs, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(0, 9, 9, 8'h00, 1'b1, 1'b0);
      get_result("post_reset", 1'b0, 16'd9, 16'h29B1, 1'b0, 0, ENG_LAT + 1);

      send(0, 70000, 70000, 8'h00, 1'b0, 1'b0);
      get_result("saturate", 1'b0, 16'hFFFF, crc_of(8'h00, 70000), 1'b0, 0, ENG_LAT + 1);

`ifdef CRC16_SCHED_TIMEOUT_EN
      send(1, 2, 10, 8'hE0, 1'b0, 1'b0);
      get_result("timeout", 1'b1, 16'd2, 16'h0000, 1'b1, 0, TMO);
      send(1, 3, 3, 8'h01, 1'b0, 1'b0);
      get_result("after_timeout", 1'b1, 16'd3, crc_of(8'h01, 3), 1'b0, 0, ENG_LAT + 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/crc16_frame_sched.md
# crc16_frame_sched

Frame-level scheduler placing two byte-stream requesters onto one shared byte-parallel CRC-16 engine. Arbitrates round-robin at frame boundaries, initialises the engine before each frame and forwards the granted frame's bytes. After the engine's fixed latency it captures the 16-bit CRC and returns it with source id and byte count on a valid/ready result port. It sits between packet sources (e.g. TX framer, RX checker) and the single `CRC_16_parallel`-style engine instance.

## Interface
- `ENG_LAT`, 2: cycles from the engine accepting the last byte (`eng_valid` high) to `eng_crc` being final; range 1–15.
- `TIMEOUT`, 255: idle-beat limit in FEED; only used with `CRC16_SCHED_TIMEOUT_EN`; range 1–65535.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req0_valid`, `req1_valid` in 1: requester byte valid.
- `req0_data`, `req1_data` in 8: requester byte.
- `req0_last`, `req1_last` in 1: byte is final of frame.
- `req0_ready`, `req1_ready` out 1: byte accepted when valid&ready.
- `eng_init` out 1: one-cycle pulse; engine loads seed.
- `eng_valid` out 1: byte strobe to engine.
- `eng_data` out 8: byte to engine.
- `eng_crc` in 16: engine CRC output.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumer accept.
- `res_crc` out 16: captured CRC.
- `res_src` out 1: requester index of the frame.
- `res_len` out 16: frame byte count, saturating at 0xFFFF.
- `res_err` out 1: frame aborted (timeout); 0 when feature compiled out.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, INIT, FEED, WAIT, DONE.
- IDLE: if any `reqN_valid`, grant. Both valid: grant `prio` (reset 0). Register `grant`, go INIT. No bytes are accepted in IDLE.
- INIT: `eng_init`=1 for one cycle, clear length counter. Go FEED.
- FEED: `req[grant]_ready`=1, other ready=0. On an accepted beat: `eng_data`←byte and `eng_valid`←1 (registered, next cycle); increment length, saturating. Accepted beat with `last`: go WAIT, load latency counter with `ENG_LAT`.
- WAIT: decrement counter each cycle. At counter==0: capture `eng_crc` into `res_crc`, and `res_len`, `res_src`. Go DONE.
- DONE: `res_valid`=1, outputs stable. On `res_valid & res_ready`: `prio`←~`grant`, go IDLE.
- Zero-length frames are impossible: a frame is at least one `last` beat, so `res_len` ≥ 1.
- Non-granted requester is held with ready=0 for the whole frame; its valid must persist (AXI-style, no drop).
- Reset mid-operation: everything returns to reset values immediately. A partial frame is discarded; the engine is re-initialised by the next INIT.

## Timing
- Reset values: all ready=0, `eng_init`=0, `eng_valid`=0, `eng_data`=0, `res_valid`=0, `res_crc`=0, `res_src`=0, `res_len`=0, `res_err`=0, `busy`=0; state IDLE, `prio`=0.
- Valid seen in IDLE at edge k: `eng_init` high in cycle k+1; ready high from cycle k+2.
- Beat accepted at edge m: `eng_valid`/`eng_data` high in cycle m+1.
- Last beat accepted at edge m: CRC captured at edge m+1+`ENG_LAT`; `res_valid` high in cycle m+2+`ENG_LAT`.
- Throughput in FEED: one byte per cycle.
- Per-frame overhead: 2 cycles (IDLE, INIT), plus `ENG_LAT`+1 cycles, plus at least 1 DONE cycle.
- `res_ready` held high in DONE: IDLE on the next cycle. A new grant is possible at the following edge.

## Configuration
- `CRC16_SCHED_TIMEOUT_EN` defined: 16-bit idle counter in FEED. It clears on every accepted beat and increments on cycles with granted valid=0. On reaching `TIMEOUT`: drop ready, set `res_err`=1, capture `res_len` (bytes so far) and `res_crc`=0, go DONE directly (skip WAIT). `res_err` clears on IDLE entry.
- Not defined: no counter; FEED waits indefinitely; `res_err` tied 0.

## Test plan
- Single frame on req0, "123456789" (9 bytes, `last` on 0x39), `ENG_LAT`=2, engine model CRC-16/CCITT-FALSE → one `eng_init` pulse; `res_crc`=0x29B1, `res_len`=9, `res_src`=0; `res_valid` exactly 2+`ENG_LAT` cycles after the last beat is accepted.
- req0 and req1 both valid continuously with 3-byte frames → grants alternate 0,1,0,1; the non-granted ready never asserts during the other's frame.
- `res_ready` held low 5 cycles in DONE → `res_valid`, `res_crc`, `res_src`, `res_len` stable; no ready asserted; next frame starts only after the handshake.
- Assert `rst_n`=0 mid-frame after 4 of 9 bytes → all outputs at reset values at once; a new "123456789" frame after release gives 0x29B1.
- Frame of 70000 bytes → `res_len`=0xFFFF (saturated), CRC equals the model.
- With `CRC16_SCHED_TIMEOUT_EN`, `TIMEOUT`=8: req1 sends 2 bytes then stalls → after 8 idle cycles `res_valid`=1, `res_err`=1, `res_len`=2, `res_crc`=0; the next frame has `res_err`=0.
